// File: rtl/helppll_loopfilter.sv
// PI loop filter for the helper-oscillator PLL: error -> outlier check -> integrate -> DAC word.
// Also tracks lock (consecutive small errors) and counts rejected or dropped samples.
module helppll_loopfilter #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DACWIDTH = 16,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned ACCWIDTH = 48,
  parameter int unsigned LOCKN    = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DWIDTH-1:0]   i_freqdiff,
  input  logic                i_stb_freqdiff,
  input  logic                i_enable,
  input  logic [DWIDTH-1:0]   i_setpoint,
  input  logic [4:0]          i_kp_sh,
  input  logic [4:0]          i_ki_sh,
  input  logic [DACWIDTH-1:0] i_dac_init,
  input  logic [DWIDTH-1:0]   i_lockthresh,
  input  logic [DWIDTH-1:0]   i_outlier,
  output logic [DACWIDTH-1:0] o_dac,
  output logic                o_dac_stb,
  output logic                o_locked,
  output logic [15:0]         o_nreject,
  output logic [ACCWIDTH-1:0] o_dbinteg
);

  // Working width leaves headroom so err<<<FRAC and integ+p never wrap.
  localparam int unsigned WW  = ACCWIDTH + 4;
  localparam int unsigned LCW = $clog2(LOCKN + 1);
  localparam logic signed [WW-1:0] ACC_MAX = WW'({1'b0, {(ACCWIDTH-1){1'b1}}});
  localparam logic signed [WW-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [WW-1:0] DAC_MAX = WW'({DACWIDTH{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_CHK, S_INTEG, S_OUT} state_t;

  state_t                      r_state;
  logic        [DWIDTH-1:0]    r_fd;
  logic signed [WW-1:0]        r_err;
  logic signed [ACCWIDTH-1:0]  r_integ;
  logic        [LCW-1:0]       r_lockcnt;
  logic        [DACWIDTH-1:0]  r_dac;
  logic                        r_dac_stb;
  logic                        r_locked;
  logic        [15:0]          r_nreject;

  logic signed [WW-1:0]        w_err_sh, w_e, w_p, w_isum, w_isat, w_pisum, w_dinit, w_v;
  logic        [WW-1:0]        w_aerr;
  logic                        w_reject, w_drop, w_hold;
  logic        [DACWIDTH-1:0]  w_dac_cl;
  logic        [LCW-1:0]       w_lockcnt_nxt;
  logic        [1:0]           w_nrej_inc;
  logic        [16:0]          w_nrej_sum;
  logic        [15:0]          w_nrej_nxt;

  always_comb begin
    w_err_sh = r_err <<< FRAC;
    w_e      = w_err_sh >>> i_ki_sh;
    w_p      = w_err_sh >>> i_kp_sh;
    w_aerr   = r_err[WW-1] ? -r_err : r_err;
    w_reject = (r_state == S_CHK) && (w_aerr > WW'(i_outlier));
    w_drop   = i_stb_freqdiff && (r_state != S_IDLE);

    w_isum = WW'(r_integ) + w_e;
    if (w_isum > ACC_MAX)      w_isat = ACC_MAX;
    else if (w_isum < ACC_MIN) w_isat = ACC_MIN;
    else                       w_isat = w_isum;

    // Positive error drives the DAC down; stop integrating into a rail.
    w_hold = ((r_dac == '0) && !w_e[WW-1] && (w_e != '0)) ||
             ((r_dac == '1) && w_e[WW-1]);

    w_dinit  = WW'(i_dac_init);
    w_pisum  = WW'(r_integ) + w_p;
    w_v      = w_dinit - (w_pisum >>> FRAC);
    if (w_v[WW-1])         w_dac_cl = '0;
    else if (w_v > DAC_MAX) w_dac_cl = '1;
    else                   w_dac_cl = DACWIDTH'(w_v);

    if (w_aerr <= WW'(i_lockthresh))
      w_lockcnt_nxt = (r_lockcnt == LCW'(LOCKN)) ? r_lockcnt : r_lockcnt + 1'b1;
    else
      w_lockcnt_nxt = '0;

    w_nrej_inc = {1'b0, w_reject} + {1'b0, w_drop};
    w_nrej_sum = {1'b0, r_nreject} + 17'(w_nrej_inc);
    w_nrej_nxt = w_nrej_sum[16] ? 16'hFFFF : w_nrej_sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_fd      <= '0;
      r_err     <= '0;
      r_integ   <= '0;
      r_lockcnt <= '0;
      r_locked  <= 1'b0;
      r_dac_stb <= 1'b0;
      r_nreject <= '0;
      r_dac     <= i_dac_init;
    end else if (!i_enable) begin
      r_state   <= S_IDLE;
      r_integ   <= '0;
      r_lockcnt <= '0;
      r_locked  <= 1'b0;
      r_dac_stb <= 1'b0;
      r_dac     <= i_dac_init;
    end else begin
      r_dac_stb <= 1'b0;
      r_nreject <= w_nrej_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_stb_freqdiff) begin
            r_fd    <= i_freqdiff;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_err   <= WW'($signed(r_fd)) - WW'($signed(i_setpoint));
          r_state <= S_CHK;
        end
        S_CHK: begin
          if (w_reject) begin
            r_lockcnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_lockcnt <= w_lockcnt_nxt;
            r_state   <= S_INTEG;
          end
        end
        S_INTEG: begin
          if (!w_hold) r_integ <= ACCWIDTH'(w_isat);
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_dac     <= w_dac_cl;
          r_dac_stb <= 1'b1;
          r_locked  <= (r_lockcnt == LCW'(LOCKN));
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dac     = r_dac;
  assign o_dac_stb = r_dac_stb;
  assign o_locked  = r_locked;
  assign o_nreject = r_nreject;
  assign o_dbinteg = r_integ;

endmodule
